// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life engines.
// Pure declarations, no logic and no latency.
// Not applicable; there is no flow control here.
package life_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_DEAD    = 2'b00;
    localparam cell_t CELL_NEWBORN = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } evo_state_t;

    // Flat cell number of (r,c) on an n-wide board, row-major.
    function automatic int cell_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

    // Toroidal step back: 0 wraps to n-1.
    function automatic int wrap_dec(input int x, input int n);
        return (x == 0) ? (n - 1) : (x - 1);
    endfunction

    // Toroidal step forward: n-1 wraps to 0.
    function automatic int wrap_inc(input int x, input int n);
        return (x == n - 1) ? 0 : (x + 1);
    endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Next-state rule for one cell given its live-neighbour count.
// Purely combinational, zero cycles.
// No flow control; output follows inputs.
module life_cell_rule
    import life_pkg::*;
(
    input  cell_t       cur_cell,
    input  logic [3:0]  count,
    output cell_t       new_cell
);

    logic alive;

    assign alive = (cur_cell != CELL_DEAD);

    // Survivors keep their colour; births get the newborn colour.
    always_comb begin
        new_cell = CELL_DEAD;
        if (alive && (count == 4'd2 || count == 4'd3)) begin
            new_cell = cur_cell;
        end else if (!alive && count == 4'd3) begin
            new_cell = CELL_NEWBORN;
        end
    end

endmodule

// File: rtl/life_evo_engine.sv
// Sequential Game-of-Life engine: one cell per clock over a private snapshot.
// N*N cycles in CALC after start, then a one-cycle done pulse (257 cycles for N=16).
// start is only honoured in IDLE; requests in CALC/DONE are dropped, not queued.
module life_evo_engine
    import life_pkg::*;
#(
    parameter int P_PARAM_N = 16
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [P_PARAM_N*P_PARAM_N*2-1:0]   prev,
    output logic [P_PARAM_N*P_PARAM_N*2-1:0]   next,
    output logic                               busy,
    output logic                               done,
    output logic [15:0]                        gen_count
);

    localparam int N    = P_PARAM_N;
    localparam int BW   = N * N * 2;
    localparam int IW   = $clog2(N);
    localparam int PADW = 32 - IW;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    evo_state_t     state_q;
    evo_state_t     state_d;
    logic [IW-1:0]  row_q;
    logic [IW-1:0]  col_q;
    logic [BW-1:0]  snap_q;
    logic [BW-1:0]  next_q;
    logic [15:0]    gen_count_q;

    logic           last_cell;
    int             cur_idx;
    cell_t          self_cell;
    cell_t          nb [8];
    logic [3:0]     nb_cnt;
    cell_t          new_cell;

    assign last_cell = (row_q == LAST) && (col_q == LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_cell) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gather the eight toroidal neighbours of the cursor cell from the snapshot and count the live ones.
    always_comb begin
        int r, c, rm, rp, cm, cp;
        r  = {{PADW{1'b0}}, row_q};
        c  = {{PADW{1'b0}}, col_q};
        rm = wrap_dec(r, N);
        rp = wrap_inc(r, N);
        cm = wrap_dec(c, N);
        cp = wrap_inc(c, N);
        cur_idx   = cell_idx(r, c, N);
        self_cell = snap_q[cur_idx*2 +: 2];
        nb[0] = snap_q[cell_idx(rm, cm, N)*2 +: 2];
        nb[1] = snap_q[cell_idx(rm, c,  N)*2 +: 2];
        nb[2] = snap_q[cell_idx(rm, cp, N)*2 +: 2];
        nb[3] = snap_q[cell_idx(r,  cm, N)*2 +: 2];
        nb[4] = snap_q[cell_idx(r,  cp, N)*2 +: 2];
        nb[5] = snap_q[cell_idx(rp, cm, N)*2 +: 2];
        nb[6] = snap_q[cell_idx(rp, c,  N)*2 +: 2];
        nb[7] = snap_q[cell_idx(rp, cp, N)*2 +: 2];
        nb_cnt = 4'd0;
        for (int k = 0; k < 8; k++) begin
            nb_cnt = nb_cnt + {3'b000, (nb[k] != CELL_DEAD)};
        end
    end

    life_cell_rule u_rule (
        .cur_cell (self_cell),
        .count    (nb_cnt),
        .new_cell (new_cell)
    );

    // Snapshot on accept, then walk the board row-major writing one result cell per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            snap_q      <= '0;
            next_q      <= '0;
            gen_count_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q <= prev;
                        row_q  <= '0;
                        col_q  <= '0;
                    end
                end
                CALC: begin
                    next_q[cur_idx*2 +: 2] <= new_cell;
                    if (col_q == LAST) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                    if (last_cell) begin
                        gen_count_q <= gen_count_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign next      = next_q;
    assign gen_count = gen_count_q;

endmodule

// File: tb/tb_life_evo_engine.sv
module tb_life_evo_engine;

    localparam int N  = 16;
    localparam int BW = N * N * 2;
    typedef logic [BW-1:0] board_t;

    logic        clk;
    logic        rst;
    logic        start;
    board_t      prev;
    board_t      next;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;

    int          n_checks;
    int          n_pass;
    logic [15:0] exp_gen;
    board_t      exp_q[$];

    life_evo_engine #(.P_PARAM_N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .prev      (prev),
        .next      (next),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic board_t put(input board_t b, input int r, input int c, input logic [1:0] v);
        board_t t;
        t = b;
        t[(r*N+c)*2 +: 2] = v;
        return t;
    endfunction

    // Reference generation using modulo arithmetic on the torus.
    function automatic board_t life_ref(input board_t b);
        board_t o;
        o = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int cnt;
                logic [1:0] me;
                cnt = 0;
                me  = b[(r*N+c)*2 +: 2];
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            if (b[(((r+dr+N)%N)*N + ((c+dc+N)%N))*2 +: 2] != 2'b00) cnt++;
                        end
                    end
                end
                if (me != 2'b00 && (cnt == 2 || cnt == 3)) o[(r*N+c)*2 +: 2] = me;
                else if (me == 2'b00 && cnt == 3) o[(r*N+c)*2 +: 2] = 2'b01;
            end
        end
        return o;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst     = 1'b0;
        exp_gen = 16'd0;
        exp_q.delete();
    endtask

    // Push expected result, pulse start, wait for done, check latency, busy width, result and gen_count.
    task automatic run_gen(input string name, input board_t b, input board_t expd);
        int cyc;
        int busy_cyc;
        board_t e;
        prev = b;
        exp_q.push_back(expd);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_cyc = 0;
        while (!done && cyc < 400) begin
            if (busy) busy_cyc++;
            tick();
            cyc++;
        end
        n_checks++;
        if (!done) begin
            $display("FAIL %s_done_timeout: no done within %0d cycles", name, cyc);
            return;
        end else n_pass++;
        n_checks++;
        if (cyc !== 257) $display("FAIL %s_latency: got %0d want 257", name, cyc);
        else n_pass++;
        n_checks++;
        if (busy_cyc !== 256) $display("FAIL %s_busy_cycles: got %0d want 256", name, busy_cyc);
        else n_pass++;
        exp_gen = exp_gen + 16'd1;
        e = exp_q.pop_front();
        n_checks++;
        if (next !== e) $display("FAIL %s_next: got %h want %h", name, next, e);
        else n_pass++;
        n_checks++;
        if (gen_count !== exp_gen) $display("FAIL %s_gen_count: got %0d want %0d", name, gen_count, exp_gen);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_after_done: done=%b busy=%b want 0 0", name, done, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (next !== '0 || busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd0)
            $display("FAIL reset_state: next=%h busy=%b done=%b gen=%0d want all zero", next, busy, done, gen_count);
        else n_pass++;
    endtask

    task automatic test_blinker();
        board_t b, e;
        b = '0;
        b = put(b, 7, 6, 2'b10);
        b = put(b, 7, 7, 2'b10);
        b = put(b, 7, 8, 2'b10);
        e = '0;
        e = put(e, 6, 7, 2'b01);
        e = put(e, 7, 7, 2'b10);
        e = put(e, 8, 7, 2'b01);
        run_gen("blinker", b, e);
    endtask

    task automatic test_block();
        board_t b;
        b = '0;
        b = put(b, 0, 0, 2'b11);
        b = put(b, 0, 1, 2'b11);
        b = put(b, 1, 0, 2'b11);
        b = put(b, 1, 1, 2'b11);
        do_reset();
        run_gen("block", b, b);
    endtask

    task automatic test_wrap();
        board_t b, e;
        b = '0;
        b = put(b, 0, 15, 2'b10);
        b = put(b, 0, 0,  2'b10);
        b = put(b, 0, 1,  2'b10);
        e = '0;
        e = put(e, 15, 0, 2'b01);
        e = put(e, 0,  0, 2'b10);
        e = put(e, 1,  0, 2'b01);
        run_gen("wrap", b, e);
    endtask

    task automatic test_full_and_dead();
        board_t b;
        b = '0;
        for (int i = 0; i < N*N; i++) b[i*2 +: 2] = 2'b01;
        run_gen("all_alive", b, '0);
        run_gen("all_dead", '0, '0);
    endtask

    // Extra starts during CALC and DONE are dropped; prev change mid-CALC is invisible.
    task automatic test_start_ignored();
        board_t b, e;
        int cyc;
        int extra_busy;
        b = '0;
        b = put(b, 7, 6, 2'b11);
        b = put(b, 7, 7, 2'b11);
        b = put(b, 7, 8, 2'b11);
        e = '0;
        e = put(e, 6, 7, 2'b01);
        e = put(e, 7, 7, 2'b11);
        e = put(e, 8, 7, 2'b01);
        do_reset();
        prev = b;
        exp_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            start = (cyc == 10);
            if (cyc == 50) prev = '1;
            tick();
            cyc++;
        end
        start = 1'b0;
        n_checks++;
        if (!done || cyc !== 257) $display("FAIL ignore_done_latency: done=%b cyc=%0d want 1 at 257", done, cyc);
        else n_pass++;
        exp_gen = exp_gen + 16'd1;
        n_checks++;
        if (next !== exp_q[0]) $display("FAIL ignore_next_snapshot: got %h want %h", next, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        start = 1'b1;
        tick();
        start = 1'b0;
        extra_busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || done) extra_busy++;
            tick();
        end
        n_checks++;
        if (extra_busy !== 0) $display("FAIL ignore_start_in_done: busy/done seen %0d cycles want 0", extra_busy);
        else n_pass++;
        n_checks++;
        if (gen_count !== exp_gen) $display("FAIL ignore_gen_count: got %0d want %0d", gen_count, exp_gen);
        else n_pass++;
    endtask

    // start held high: next generation starts on the first IDLE cycle after DONE.
    task automatic test_back_to_back();
        board_t b, g1, g2;
        int cyc;
        b = '0;
        for (int i = 0; i < N*N; i++) b[i*2 +: 2] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        g1 = life_ref(b);
        g2 = life_ref(g1);
        exp_q.push_back(g1);
        exp_q.push_back(g2);
        prev  = b;
        start = 1'b1;
        for (int g = 0; g < 2; g++) begin
            tick();
            cyc = 1;
            while (!done && cyc < 400) begin
                tick();
                cyc++;
            end
            exp_gen = exp_gen + 16'd1;
            n_checks++;
            if (!done || cyc !== 257) $display("FAIL b2b_latency_%0d: done=%b cyc=%0d want 1 at 257", g, done, cyc);
            else n_pass++;
            n_checks++;
            if (next !== exp_q[0]) $display("FAIL b2b_next_%0d: got %h want %h", g, next, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
            prev = g1;
            tick();
            if (g == 1) start = 1'b0;
        end
        tick();
        n_checks++;
        if (gen_count !== exp_gen || busy !== 1'b0) $display("FAIL b2b_end: gen=%0d busy=%b want %0d 0", gen_count, busy, exp_gen);
        else n_pass++;
    endtask

    // Reset mid-CALC aborts with no done; reset beats a simultaneous start.
    task automatic test_rst_mid_calc();
        board_t b;
        int seen_done;
        b = '0;
        b = put(b, 3, 3, 2'b01);
        b = put(b, 3, 4, 2'b01);
        b = put(b, 3, 5, 2'b01);
        prev  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_gen = 16'd0;
        n_checks++;
        if (next !== '0 || busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd0)
            $display("FAIL rst_mid_calc: next=%h busy=%b done=%b gen=%0d want all zero", next, busy, done, gen_count);
        else n_pass++;
        seen_done = 0;
        for (int i = 0; i < 300; i++) begin
            if (done || busy) seen_done++;
            tick();
        end
        n_checks++;
        if (seen_done !== 0) $display("FAIL rst_no_done: activity on %0d cycles want 0", seen_done);
        else n_pass++;
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_beats_start: busy=%b want 0", busy);
        else n_pass++;
        run_gen("after_rst", b, life_ref(b));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_gen  = 16'd0;
        rst      = 1'b1;
        start    = 1'b0;
        prev     = '0;
        test_reset();
        test_blinker();
        test_block();
        test_wrap();
        test_full_and_dead();
        test_start_ignored();
        test_back_to_back();
        test_rst_mid_calc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
